multicycle_control: RTL and testbench

Multicycle MIPS control FSM that generates the per-cycle datapath controls and the 4-bit ALUOp consumed by the ULA. It also consumes the ULA Zero flag to resolve branches. It sits between the instruction register (opcode/funct) and the datapath muxes, memory and register file, and keeps a retired-instruction counter for bring-up.

---
 rtl/mips_ctrl_pkg.sv | 71 +++++++
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control_alu_decoder.sv | 56 +++++
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

    // Control FSM states; encoding is visible on state_o for debug.
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        I_EXEC    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11
    } state_t;

    // Which table the ALU decoder should consult this cycle.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_R    = 2'd1,
        CLS_I    = 2'd2,
        CLS_BR   = 2'd3
    } alu_cls_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MULT = 4'd2;
    localparam logic [3:0] ALU_DIV  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_NOT  = 4'd6;
    localparam logic [3:0] ALU_SL   = 4'd7;
    localparam logic [3:0] ALU_SR   = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BGT  = 4'd12;
    localparam logic [3:0] ALU_BLT  = 4'd13;
    localparam logic [3:0] ALU_BGE  = 4'd14;
    localparam logic [3:0] ALU_BLE  = 4'd15;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BGT  = 6'h07;
    localparam logic [5:0] OP_BLT  = 6'h16;
    localparam logic [5:0] OP_BGE  = 6'h17;
    localparam logic [5:0] OP_BLE  = 6'h06;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOT  = 6'h27;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the instruction register/ULA and the control FSM.
// There is no valid/ready handshake: the controller drives a fresh set of
// strobes every cycle and the datapath acts on them at the next rising edge.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             Zero;
    logic [3:0]       ALUOp;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             RegWrite;
    logic [1:0]       PCSource;
    logic             pc_en;
    logic             illegal;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, Zero,
        output ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, PCSource, pc_en, illegal,
               state_o, retired
    );

    modport slave (
        output opcode, funct, Zero,
        input  ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemtoReg, RegWrite, PCSource, pc_en, illegal,
               state_o, retired
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Maps R-type funct, I-type opcode or branch opcode to a ULA operation.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       valid
);

    // Table lookup; valid drops when the selected table has no entry.
    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (cls)
            CLS_R: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_MULT: alu_op = ALU_MULT;
                    FN_DIV:  alu_op = ALU_DIV;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_NOT:  alu_op = ALU_NOT;
                    FN_SLL:  alu_op = ALU_SL;
                    FN_SRL:  alu_op = ALU_SR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: valid  = 1'b0;
                endcase
            end
            CLS_I: begin
                case (opcode)
                    OP_ADDI: alu_op = ALU_ADD;
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: valid  = 1'b0;
                endcase
            end
            CLS_BR: begin
                case (opcode)
                    OP_BEQ:  alu_op = ALU_BEQ;
                    OP_BNE:  alu_op = ALU_BNE;
                    OP_BGT:  alu_op = ALU_BGT;
                    OP_BLT:  alu_op = ALU_BLT;
                    OP_BGE:  alu_op = ALU_BGE;
                    OP_BLE:  alu_op = ALU_BLE;
                    default: valid  = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with retired-instruction counter.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  logic clk,
    input  logic rst,
    multicycle_control_if.master bus
);

    state_t           state, next_state;
    alu_cls_t         cls;
    logic [3:0]       dec_op, alu_op;
    logic             dec_valid;
    logic [CNT_W-1:0] retired_q;
    logic             retire, bad_instr;
    logic             src_a, iord, mem_rd, mem_wr, ir_wr;
    logic             reg_dst, mem_to_reg, reg_wr, pc_write, pc_write_cond;
    logic [1:0]       src_b, pc_src;

    alu_decoder u_dec (
        .cls    (cls),
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .alu_op (dec_op),
        .valid  (dec_valid)
    );

    // Decoder table select; DECODE peeks at the R table to vet funct early.
    always_comb begin
        cls = CLS_NONE;
        case (state)
            DECODE: cls = (bus.opcode == OP_R) ? CLS_R : CLS_NONE;
            R_EXEC: cls = CLS_R;
            I_EXEC: cls = CLS_I;
            BRANCH: cls = CLS_BR;
            default: cls = CLS_NONE;
        endcase
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            retired_q <= '0;
        end else begin
            state <= next_state;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    // Next state and Moore control decode.
    always_comb begin
        next_state    = state;
        alu_op        = ALU_ADD;
        src_a         = 1'b0;
        src_b         = 2'b00;
        iord          = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        ir_wr         = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_wr        = 1'b0;
        pc_src        = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        retire        = 1'b0;
        bad_instr     = 1'b0;
        case (state)
            FETCH: begin
                mem_rd     = 1'b1;
                ir_wr      = 1'b1;
                src_b      = 2'b01;
                pc_write   = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                src_b      = 2'b11;
                next_state = FETCH;
                case (bus.opcode)
                    OP_R: begin
                        if (dec_valid) next_state = R_EXEC;
                        else           bad_instr  = 1'b1;
                    end
                    OP_LW, OP_SW:                     next_state = MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = I_EXEC;
                    OP_BEQ, OP_BNE, OP_BGT,
                    OP_BLT, OP_BGE, OP_BLE:           next_state = BRANCH;
                    OP_J:                              next_state = JUMP;
                    default:                           bad_instr  = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                src_a      = 1'b1;
                src_b      = 2'b10;
                next_state = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_rd     = 1'b1;
                iord       = 1'b1;
                next_state = MEM_WB;
            end
            MEM_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            MEM_WRITE: begin
                mem_wr     = 1'b1;
                iord       = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            R_EXEC: begin
                src_a      = 1'b1;
                alu_op     = dec_op;
                next_state = R_WB;
            end
            R_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            I_EXEC: begin
                src_a      = 1'b1;
                src_b      = 2'b10;
                alu_op     = dec_op;
                next_state = I_WB;
            end
            I_WB: begin
                reg_wr     = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                src_a         = 1'b1;
                alu_op        = dec_op;
                pc_src        = 2'b01;
                pc_write_cond = 1'b1;
                retire        = 1'b1;
                next_state    = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                retire     = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // Output stage: everything is held at zero while reset is asserted.
    always_comb begin
        bus.ALUOp    = '0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = '0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.PCSource = '0;
        bus.pc_en    = 1'b0;
        bus.illegal  = 1'b0;
        bus.state_o  = '0;
        bus.retired  = '0;
        if (!rst) begin
            bus.ALUOp    = alu_op;
            bus.ALUSrcA  = src_a;
            bus.ALUSrcB  = src_b;
            bus.IorD     = iord;
            bus.MemRead  = mem_rd;
            bus.MemWrite = mem_wr;
            bus.IRWrite  = ir_wr;
            bus.RegDst   = reg_dst;
            bus.MemtoReg = mem_to_reg;
            bus.RegWrite = reg_wr;
            bus.PCSource = pc_src;
            bus.pc_en    = pc_write | (pc_write_cond & bus.Zero);
            bus.illegal  = bad_instr;
            bus.state_o  = state;
            bus.retired  = retired_q;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for the multicycle control FSM (counter width 4).
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       regdst;
        logic       memtoreg;
        logic       regwr;
        logic [1:0] pcsrc;
        logic       pc_en;
        logic       illegal;
    } snap_t;

    logic  clk = 1'b0;
    logic  rst;
    int    errors = 0;
    int    checks = 0;
    snap_t trace[$];

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic snap_t snap();
        snap_t s;
        s.st       = bus.state_o;
        s.aluop    = bus.ALUOp;
        s.srca     = bus.ALUSrcA;
        s.srcb     = bus.ALUSrcB;
        s.iord     = bus.IorD;
        s.mrd      = bus.MemRead;
        s.mwr      = bus.MemWrite;
        s.irw      = bus.IRWrite;
        s.regdst   = bus.RegDst;
        s.memtoreg = bus.MemtoReg;
        s.regwr    = bus.RegWrite;
        s.pcsrc    = bus.PCSource;
        s.pc_en    = bus.pc_en;
        s.illegal  = bus.illegal;
        return s;
    endfunction

    // Start at a negedge in FETCH; record one snapshot per cycle until the
    // FSM is back in FETCH (bounded at 12 cycles).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int n;
        trace.delete();
        bus.opcode = op;
        bus.funct  = fn;
        bus.Zero   = z;
        #1;
        n = 0;
        do begin
            trace.push_back(snap());
            @(negedge clk);
            n++;
        end while (bus.state_o != 4'd0 && n < 12);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = OP_LW;
        bus.funct  = 6'h00;
        bus.Zero   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.IorD, bus.MemRead, bus.MemWrite,
                 bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.PCSource,
                 bus.pc_en, bus.illegal, bus.state_o, bus.retired} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: some output nonzero (MemRead=%b pc_en=%b state=%0d) required all 0",
                         i, bus.MemRead, bus.pc_en, bus.state_o);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state_o !== 4'd0 || bus.MemRead !== 1'b1 || bus.IRWrite !== 1'b1 ||
            bus.pc_en !== 1'b1 || bus.ALUSrcB !== 2'b01 || bus.retired !== 4'd0) begin
            errors++;
            $display("FAIL first_fetch: state=%0d MemRead=%b IRWrite=%b pc_en=%b ALUSrcB=%b retired=%0d required 0 1 1 1 01 0",
                     bus.state_o, bus.MemRead, bus.IRWrite, bus.pc_en, bus.ALUSrcB, bus.retired);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [2]  = '{FN_SUB, FN_SLT};
        logic [3:0] ops [2]  = '{4'd1, 4'd9};
        for (int k = 0; k < 2; k++) begin
            run_instr(OP_R, fns[k], 1'b0);
            checks++;
            if (trace.size() !== 4) begin
                errors++;
                $display("FAIL r_cycles funct=%h: got %0d required 4", fns[k], trace.size());
            end else begin
                checks++;
                if (trace[1].st !== 4'd1 || trace[1].srcb !== 2'b11 || trace[2].st !== 4'd6 ||
                    trace[2].aluop !== ops[k] || trace[2].srca !== 1'b1 || trace[2].srcb !== 2'b00) begin
                    errors++;
                    $display("FAIL r_exec funct=%h: st=%0d aluop=%0d srca=%b srcb=%b required 6 %0d 1 00",
                             fns[k], trace[2].st, trace[2].aluop, trace[2].srca, trace[2].srcb, ops[k]);
                end
                checks++;
                if (trace[3].st !== 4'd7 || trace[3].regwr !== 1'b1 || trace[3].regdst !== 1'b1) begin
                    errors++;
                    $display("FAIL r_wb funct=%h: st=%0d regwr=%b regdst=%b required 7 1 1",
                             fns[k], trace[3].st, trace[3].regwr, trace[3].regdst);
                end
            end
        end
        checks++;
        if (bus.retired !== 4'd2) begin
            errors++;
            $display("FAIL r_retired: got %0d required 2", bus.retired);
        end
    endtask

    task automatic test_mem();
        int wr_count;
        run_instr(OP_LW, 6'h00, 1'b0);
        checks++;
        if (trace.size() !== 5) begin
            errors++;
            $display("FAIL lw_cycles: got %0d required 5", trace.size());
        end else begin
            checks++;
            if (trace[2].st !== 4'd2 || trace[2].srca !== 1'b1 || trace[2].srcb !== 2'b10) begin
                errors++;
                $display("FAIL lw_addr: st=%0d srca=%b srcb=%b required 2 1 10",
                         trace[2].st, trace[2].srca, trace[2].srcb);
            end
            checks++;
            if (trace[3].st !== 4'd3 || trace[3].mrd !== 1'b1 || trace[3].iord !== 1'b1 || trace[3].regwr !== 1'b0) begin
                errors++;
                $display("FAIL lw_read: st=%0d mrd=%b iord=%b regwr=%b required 3 1 1 0",
                         trace[3].st, trace[3].mrd, trace[3].iord, trace[3].regwr);
            end
            checks++;
            if (trace[4].st !== 4'd4 || trace[4].regwr !== 1'b1 || trace[4].memtoreg !== 1'b1 || trace[4].regdst !== 1'b0) begin
                errors++;
                $display("FAIL lw_wb: st=%0d regwr=%b memtoreg=%b regdst=%b required 4 1 1 0",
                         trace[4].st, trace[4].regwr, trace[4].memtoreg, trace[4].regdst);
            end
        end
        run_instr(OP_SW, 6'h00, 1'b0);
        wr_count = 0;
        foreach (trace[i]) if (trace[i].mwr === 1'b1) wr_count++;
        checks++;
        if (trace.size() !== 4 || wr_count !== 1 || trace[trace.size()-1].st !== 4'd5 ||
            trace[trace.size()-1].iord !== 1'b1) begin
            errors++;
            $display("FAIL sw_seq: cycles=%0d writes=%0d last_st=%0d required 4 1 5",
                     trace.size(), wr_count, trace[trace.size()-1].st);
        end
        checks++;
        if (bus.retired !== 4'd4) begin
            errors++;
            $display("FAIL mem_retired: got %0d required 4", bus.retired);
        end
    endtask

    task automatic test_branch();
        logic [5:0] bops [3] = '{OP_BEQ, OP_BNE, OP_BLE};
        logic       zs   [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0] aops [3] = '{4'd10, 4'd11, 4'd15};
        for (int k = 0; k < 3; k++) begin
            run_instr(bops[k], 6'h3F, zs[k]);
            checks++;
            if (trace.size() !== 3) begin
                errors++;
                $display("FAIL br_cycles op=%h: got %0d required 3", bops[k], trace.size());
            end else begin
                checks++;
                if (trace[2].st !== 4'd10 || trace[2].aluop !== aops[k] || trace[2].pc_en !== zs[k] ||
                    trace[2].pcsrc !== 2'b01 || trace[2].srca !== 1'b1 || trace[2].srcb !== 2'b00) begin
                    errors++;
                    $display("FAIL br_exec op=%h: st=%0d aluop=%0d pc_en=%b pcsrc=%b required 10 %0d %b 01",
                             bops[k], trace[2].st, trace[2].aluop, trace[2].pc_en, trace[2].pcsrc, aops[k], zs[k]);
                end
            end
        end
        checks++;
        if (bus.retired !== 4'd7) begin
            errors++;
            $display("FAIL br_retired: got %0d required 7", bus.retired);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] iops [2] = '{6'h3F, OP_R};
        for (int k = 0; k < 2; k++) begin
            run_instr(iops[k], 6'h3F, 1'b0);
            checks++;
            if (trace.size() !== 2 || trace[0].illegal !== 1'b0 || trace[1].illegal !== 1'b1 ||
                trace[1].st !== 4'd1 || bus.illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse case %0d: cycles=%0d ill=%b%b now=%b required 2 01 0",
                         k, trace.size(), trace[0].illegal, trace[1].illegal, bus.illegal);
            end
        end
        checks++;
        if (bus.retired !== 4'd7) begin
            errors++;
            $display("FAIL illegal_retired: got %0d required 7", bus.retired);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 15; k++) run_instr(OP_J, 6'h00, 1'b0);
        checks++;
        if (trace.size() !== 3 || trace[2].st !== 4'd11 || trace[2].pcsrc !== 2'b10 || trace[2].pc_en !== 1'b1) begin
            errors++;
            $display("FAIL jump_seq: cycles=%0d st=%0d pcsrc=%b pc_en=%b required 3 11 10 1",
                     trace.size(), trace[2].st, trace[2].pcsrc, trace[2].pc_en);
        end
        checks++;
        if (bus.retired !== 4'd15) begin
            errors++;
            $display("FAIL retired_full: got %0d required 15", bus.retired);
        end
        run_instr(OP_J, 6'h00, 1'b0);
        checks++;
        if (bus.retired !== 4'd0) begin
            errors++;
            $display("FAIL retired_wrap: got %0d required 0", bus.retired);
        end
    endtask

    task automatic test_abort();
        bus.opcode = OP_LW;
        #1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.state_o !== 4'd3 || bus.MemRead !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: state=%0d MemRead=%b required 3 1", bus.state_o, bus.MemRead);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.MemRead, bus.IorD, bus.RegWrite, bus.state_o} !== '0) begin
            errors++;
            $display("FAIL abort_forced: MemRead=%b IorD=%b RegWrite=%b state=%0d required all 0",
                     bus.MemRead, bus.IorD, bus.RegWrite, bus.state_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state_o !== 4'd0 || bus.RegWrite !== 1'b0 || bus.retired !== 4'd0) begin
            errors++;
            $display("FAIL abort_after: state=%0d RegWrite=%b retired=%0d required 0 0 0",
                     bus.state_o, bus.RegWrite, bus.retired);
        end
        @(negedge clk);
        checks++;
        if (bus.state_o !== 4'd1 || bus.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: state=%0d RegWrite=%b required 1 0", bus.state_o, bus.RegWrite);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_branch();
        test_illegal();
        test_wrap();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
